keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It owns the keypad column drive and sequences the columns one at a time. It synchronizes and debounces the row returns, then produces a one-cycle key event. It keeps the last two accepted key codes for the seven-segment display path.

Parameters:
SCAN_DIV, 5000, clk cycles per scan tick; column dwell time. Minimum 2.
DEBOUNCE_TICKS, 4, consecutive ticks of stable level needed to accept a press or a release. Minimum 1.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rows  input  4  keypad row returns; active-low, externally pulled up, asynchronous to clk
cols  output  4  keypad column drive; active-low, exactly one bit low at any time
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_code  output  4  code of the accepted key, {row_idx[1:0], col_idx[1:0]}; valid while key_valid=1, holds until the next press
key_held  output  1  high from acceptance until the release is debounced
last  output  4  most recent accepted code
lastlast  output  4  code accepted before last

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-low. All flops clear on reset=0, regardless of clk.
- Reset values: cols=4'b1110 (col 0 driven), key_valid=0, key_code=0, key_held=0, last=0, lastlast=0, state=SCAN, column index=0, all counters=0.
- Synchronizer: rows passes through 2 flops giving rs. All decisions use rs only.
- Tick counter: counts 0..SCAN_DIV-1 and wraps. tick=1 in the cycle where count==SCAN_DIV-1. The counter free-runs in all states.
- Row select: hit=|(~rs). If more than one row is low, the lowest index wins (row_idx).
- States:
  - SCAN: on tick with hit=0, advance the column index (3 wraps to 0) and update cols on the next edge. On tick with hit=1, latch row_idx and the current col, set deb_cnt=1, go to PRESS_DEB. The column is not advanced.
  - PRESS_DEB: on tick, if rs[latched row]=0, deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, go to HELD. If rs[latched row]=1 on a tick, abort to SCAN, advance the column and clear deb_cnt. With DEBOUNCE_TICKS=1, acceptance happens on entry, i.e. the tick that detected the hit.
  - HELD: on acceptance, pulse key_valid for 1 cycle. In the same edge set key_code to the latched code, lastlast to the old last, last to the new code, and key_held to 1. On a tick with rs[latched row]=1, set deb_cnt=1 and go to REL_DEB.
  - REL_DEB: on tick, if rs[latched row]=1, deb_cnt++. When deb_cnt reaches DEBOUNCE_TICKS, clear key_held, advance the column and go to SCAN. If the row is low again on a tick, return to HELD with no new key_valid.
- Column frozen: cols does not change in PRESS_DEB, HELD or REL_DEB.
- Held keys: a held key produces exactly one key_valid. A second key pressed in another column while one is held is ignored. A second key in the same column on a lower-index row does not change the latched row.
- Latency: key_valid rises 1 clk after the tick on which the debounce count completes.
- Reset mid-operation (any state): immediate return to reset values. No key_valid is emitted.
- Counter widths: $clog2(SCAN_DIV) for the tick counter, $clog2(DEBOUNCE_TICKS+1) for deb_cnt. deb_cnt saturates and never wraps.

Test Plan:
1. Reset: hold reset=0 with rows=4'b0000. Required: cols=1110, key_valid=0, last=lastlast=0. Release with rows=1111. Required: cols steps 1110→1101→1011→0111→1110, one step every SCAN_DIV clks.
2. Clean press: SCAN_DIV=4, DEBOUNCE_TICKS=3; drive row 2 low only while col 1 is driven, hold 40 clks. Required: one key_valid, key_code=4'b1001, last=9, key_held=1, cols frozen at 1101.
3. Bounce: toggle row 2 low/high for 1 tick each, three times, before holding it low. Required: no key_valid during the toggling. After the hold, exactly one key_valid with code 9.
4. Release and history: press code 9, release it for 3+ ticks, then press row 0 at col 3. Required: key_held falls after the release debounce. Second key_valid gives key_code=3, last=3, lastlast=9.
5. Multi-key: rows=4'b1010 while col 0 is driven. Required: code=4'b0000 (row 0 wins). Pressing col 2 while the first key is held produces no event.
6. Async reset in HELD: drop reset mid-clock. Required: outputs clear immediately with no clk edge. After release with rows=1111, scanning resumes at col 0 and no spurious key_valid occurs.

Source files
------------

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side and key-event signals of the 4x4 keypad scan controller.
// The controller uses the master modport; the keypad/display side uses the slave modport.
interface keypad_scan_ctrl_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;
  logic [3:0] last;
  logic [3:0] lastlast;

  modport master (
    input  rows,
    output cols, key_valid, key_code, key_held, last, lastlast
  );

  modport slave (
    output rows,
    input  cols, key_valid, key_code, key_held, last, lastlast
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: walks the active-low columns, debounces the row returns
// and emits one key event per press, keeping the last two accepted codes.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  keypad_scan_ctrl_if.master kp
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_TICKS);
  localparam bit            DEB_ONE   = (DEBOUNCE_TICKS == 1);

  typedef enum logic [1:0] {SCAN, PRESS_DEB, HELD, REL_DEB} state_e;

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, rs_q;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cols_q, cols_d;
  logic [1:0]    row_q, row_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    last_q, last_d;
  logic [3:0]    lastlast_q, lastlast_d;

  logic          tick;
  logic          hit;
  logic [1:0]    row_sel;
  logic          row_up;
  logic [DW-1:0] deb_inc;

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign hit     = ~&rs_q;
  assign row_up  = rs_q[row_q];
  assign deb_inc = (deb_q == DEB_DONE) ? deb_q : deb_q + DW'(1);

  always_comb begin
    row_sel = 2'd3;
    if      (!rs_q[0]) row_sel = 2'd0;
    else if (!rs_q[1]) row_sel = 2'd1;
    else if (!rs_q[2]) row_sel = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    deb_d       = deb_q;
    col_d       = col_q;
    cols_d      = cols_q;
    row_d       = row_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_held_d  = key_held_q;
    last_d      = last_q;
    lastlast_d  = lastlast_q;

    unique case (state_q)
      SCAN: begin
        if (tick && hit) begin
          row_d = row_sel;
          deb_d = DW'(1);
          if (DEB_ONE) begin
            // A single-tick debounce accepts on the detecting tick itself.
            state_d     = HELD;
            deb_d       = '0;
            key_valid_d = 1'b1;
            key_code_d  = {row_sel, col_q};
            last_d      = {row_sel, col_q};
            lastlast_d  = last_q;
            key_held_d  = 1'b1;
          end else begin
            state_d = PRESS_DEB;
          end
        end else if (tick) begin
          col_d  = col_q + 2'd1;
          cols_d = {cols_q[2:0], cols_q[3]};
        end
      end

      PRESS_DEB: begin
        if (tick && !row_up) begin
          deb_d = deb_inc;
          if (deb_inc == DEB_DONE) begin
            state_d     = HELD;
            deb_d       = '0;
            key_valid_d = 1'b1;
            key_code_d  = {row_q, col_q};
            last_d      = {row_q, col_q};
            lastlast_d  = last_q;
            key_held_d  = 1'b1;
          end
        end else if (tick) begin
          state_d = SCAN;
          deb_d   = '0;
          col_d   = col_q + 2'd1;
          cols_d  = {cols_q[2:0], cols_q[3]};
        end
      end

      HELD: begin
        if (tick && row_up) begin
          if (DEB_ONE) begin
            state_d    = SCAN;
            deb_d      = '0;
            key_held_d = 1'b0;
            col_d      = col_q + 2'd1;
            cols_d     = {cols_q[2:0], cols_q[3]};
          end else begin
            state_d = REL_DEB;
            deb_d   = DW'(1);
          end
        end
      end

      REL_DEB: begin
        if (tick && row_up) begin
          deb_d = deb_inc;
          if (deb_inc == DEB_DONE) begin
            state_d    = SCAN;
            deb_d      = '0;
            key_held_d = 1'b0;
            col_d      = col_q + 2'd1;
            cols_d     = {cols_q[2:0], cols_q[3]};
          end
        end else if (tick) begin
          // Row dropped again before the release settled: still the same press.
          state_d = HELD;
          deb_d   = '0;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // Synchronizer flops reset to the idle (pulled-up) row level so no phantom press follows reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= 4'hF;
      rs_q        <= 4'hF;
      state_q     <= SCAN;
      tick_cnt_q  <= '0;
      deb_q       <= '0;
      col_q       <= 2'd0;
      cols_q      <= 4'b1110;
      row_q       <= 2'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      key_held_q  <= 1'b0;
      last_q      <= 4'd0;
      lastlast_q  <= 4'd0;
    end else begin
      sync1_q     <= kp.rows;
      rs_q        <= sync1_q;
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      deb_q       <= deb_d;
      col_q       <= col_d;
      cols_q      <= cols_d;
      row_q       <= row_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_held_q  <= key_held_d;
      last_q      <= last_d;
      lastlast_q  <= lastlast_d;
    end
  end

  assign kp.cols      = cols_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_held  = key_held_q;
  assign kp.last      = last_q;
  assign kp.lastlast  = lastlast_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model closes rows through the driven column,
// a vector table walks press/hold/release cases, hand sequences cover reset, bounce and latency.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;

  logic clk = 1'b0;
  logic reset;
  keypad_scan_ctrl_if kp();

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DEB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Key bit r*4+c pressed connects row r to column c.
  logic [15:0] keys;
  logic        force_en;
  logic [3:0]  force_rows;
  logic [3:0]  rows_m;

  always_comb begin
    rows_m = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !kp.cols[c]) rows_m[r] = 1'b0;
  end
  assign kp.rows = force_en ? force_rows : rows_m;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          cycles;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
    logic [3:0]  exp_last;
    logic [3:0]  exp_ll;
    logic        chk_cols;
    logic [3:0]  exp_cols;
  } vec_t;

  localparam int NV = 11;
  vec_t vt[NV];

  int checks = 0;
  int errors = 0;
  int cyc, pulses, first_pulse;

  function automatic vec_t mk(input string n, input logic [15:0] k, input int cy, input int p,
                              input logic [3:0] code, input logic held, input logic [3:0] l,
                              input logic [3:0] ll, input logic cc, input logic [3:0] cols);
    vec_t v;
    v.name = n; v.keys = k; v.cycles = cy; v.exp_pulses = p; v.exp_code = code;
    v.exp_held = held; v.exp_last = l; v.exp_ll = ll; v.chk_cols = cc; v.exp_cols = cols;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      if (kp.key_valid === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = cyc;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset       = 1'b1;
    cyc         = 0;
    pulses      = 0;
    first_pulse = -1;
  endtask

  initial begin
    logic [3:0] exp_c;
    reset      = 1'b0;
    keys       = 16'h0000;
    force_en   = 1'b1;
    force_rows = 4'b0000;
    cyc = 0; pulses = 0; first_pulse = -1;

    vt[0]  = mk("press9",    16'h0200, 40, 1, 4'h9, 1'b1, 4'h9, 4'h0, 1'b1, 4'b1101);
    vt[1]  = mk("hold9",     16'h0200, 40, 0, 4'h9, 1'b1, 4'h9, 4'h0, 1'b1, 4'b1101);
    vt[2]  = mk("rel9",      16'h0000, 40, 0, 4'h9, 1'b0, 4'h9, 4'h0, 1'b0, 4'b0000);
    vt[3]  = mk("press3",    16'h0008, 40, 1, 4'h3, 1'b1, 4'h3, 4'h9, 1'b1, 4'b0111);
    vt[4]  = mk("rel3",      16'h0000, 40, 0, 4'h3, 1'b0, 4'h3, 4'h9, 1'b0, 4'b0000);
    vt[5]  = mk("multi",     16'h0101, 40, 1, 4'h0, 1'b1, 4'h0, 4'h3, 1'b1, 4'b1110);
    vt[6]  = mk("othercol",  16'h0141, 40, 0, 4'h0, 1'b1, 4'h0, 4'h3, 1'b1, 4'b1110);
    vt[7]  = mk("relmulti",  16'h0000, 40, 0, 4'h0, 1'b0, 4'h0, 4'h3, 1'b0, 4'b0000);
    vt[8]  = mk("press8",    16'h0100, 40, 1, 4'h8, 1'b1, 4'h8, 4'h0, 1'b1, 4'b1110);
    vt[9]  = mk("lowerrow",  16'h0101, 40, 0, 4'h8, 1'b1, 4'h8, 4'h0, 1'b1, 4'b1110);
    vt[10] = mk("rel8",      16'h0000, 40, 0, 4'h8, 1'b0, 4'h8, 4'h0, 1'b0, 4'b0000);

    // Reset held with all rows low, then released idle: column walk timing.
    repeat (3) @(negedge clk);
    check("rst cols", kp.cols, 4'b1110);
    check("rst valid", kp.key_valid, 1'b0);
    check("rst held", kp.key_held, 1'b0);
    check("rst code", kp.key_code, 4'h0);
    check("rst last", kp.last, 4'h0);
    check("rst lastlast", kp.lastlast, 4'h0);
    force_en = 1'b0;
    reset    = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      run(1);
      exp_c = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check($sformatf("walk cols k=%0d", k), kp.cols, exp_c);
    end
    check("walk pulses", pulses, 0);

    // Press latency: detect at tick edge 8, accept at edge 16.
    do_reset();
    keys = 16'h0200;
    run(40);
    check("lat first", first_pulse, 16);
    check("lat pulses", pulses, 1);
    check("lat code", kp.key_code, 4'h9);
    check("lat cols", kp.cols, 4'b1101);

    // Vector table, continuing from a fresh reset.
    keys = 16'h0000;
    do_reset();
    for (int i = 0; i < NV; i++) begin
      keys   = vt[i].keys;
      pulses = 0;
      run(vt[i].cycles);
      check({vt[i].name, " pulses"}, pulses, vt[i].exp_pulses);
      check({vt[i].name, " code"}, kp.key_code, vt[i].exp_code);
      check({vt[i].name, " held"}, kp.key_held, vt[i].exp_held);
      check({vt[i].name, " last"}, kp.last, vt[i].exp_last);
      check({vt[i].name, " lastlast"}, kp.lastlast, vt[i].exp_ll);
      if (vt[i].chk_cols) check({vt[i].name, " cols"}, kp.cols, vt[i].exp_cols);
    end

    // Bounce: one-tick low/high toggles, the first low lands on column 1.
    keys = 16'h0000;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 1) ? 16'h0200 : 16'h0000;
      run(4);
    end
    check("bounce pulses", pulses, 0);
    check("bounce held", kp.key_held, 1'b0);
    check("bounce cols", kp.cols, 4'b1101);
    keys = 16'h0200;
    run(40);
    check("bounce hold pulses", pulses, 1);
    check("bounce hold first", first_pulse, 36);
    check("bounce hold code", kp.key_code, 4'h9);
    check("bounce hold held", kp.key_held, 1'b1);

    // Asynchronous reset while HELD, mid clock-high phase.
    @(negedge clk);
    #7;
    reset = 1'b0;
    #1;
    check("async cols", kp.cols, 4'b1110);
    check("async held", kp.key_held, 1'b0);
    check("async code", kp.key_code, 4'h0);
    check("async last", kp.last, 4'h0);
    check("async valid", kp.key_valid, 1'b0);
    @(negedge clk);
    keys        = 16'h0000;
    reset       = 1'b1;
    cyc         = 0;
    pulses      = 0;
    first_pulse = -1;
    run(2);
    check("resume cols0", kp.cols, 4'b1110);
    run(4);
    check("resume cols1", kp.cols, 4'b1101);
    run(34);
    check("resume pulses", pulses, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
